// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Shared types and helpers for the 1-to-N stream demultiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Select width for N channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_out_slot.sv
// ============================================================================
// Module : demux_out_slot
// One-entry output register slice with valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // A load takes priority over a drain so back-to-back beats leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_last  <= load_last;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign last  = r_last;

endmodule

`default_nettype wire

// File: rtl/demux_stream_n.sv
// ============================================================================
// Module : demux_stream_n
// 1-to-NUM_OUT stream demux; destination locked per packet, registered outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_stream_n
  import demux_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_OUT = 4,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = clog2_min1(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [CNT_W-1:0]          drop_cnt
);

  state_t             r_state;
  state_t             w_next_state;
  logic [SEL_W-1:0]   r_locked_sel;
  logic [SEL_W-1:0]   w_tgt;
  logic               w_tgt_ok;
  logic               w_capture_sel;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_drop;
  logic [NUM_OUT-1:0] w_load;
  logic [CNT_W-1:0]   r_drop_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_locked_sel <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture_sel) begin
        r_locked_sel <= in_sel;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && !in_last) w_next_state = LOCKED;
      LOCKED:  if (w_accept && in_last)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: the effective target and when to latch it
  always_comb begin
    w_tgt         = in_sel;
    w_capture_sel = 1'b0;
    case (r_state)
      IDLE: begin
        w_tgt         = in_sel;
        w_capture_sel = w_accept && !in_last;
      end
      LOCKED: begin
        w_tgt = r_locked_sel;
      end
      default: begin
        w_tgt = in_sel;
      end
    endcase
  end

  assign w_tgt_ok = (int'(w_tgt) < NUM_OUT);

  // Out-of-range targets fall through the loop and keep ready high so they drain.
  always_comb begin
    w_in_ready = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_tgt == SEL_W'(k)) begin
        w_in_ready = !out_valid[k] || out_ready[k];
      end
    end
  end

  assign in_ready = w_in_ready;
  assign w_accept = in_valid && w_in_ready;
  assign w_drop   = w_accept && !w_tgt_ok;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign w_load[k] = w_accept && (w_tgt == SEL_W'(k));

    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[k]),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*DATA_W +: DATA_W]),
      .last      (out_last[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_demux_stream_n.sv
// ============================================================================
// Module : tb_demux_stream_n
// Scoreboard bench for demux_stream_n with a 3-channel, 4-bit-counter instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_stream_n;

  localparam int DATA_W  = 8;
  localparam int NUM_OUT = 3;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [DATA_W-1:0]         in_data = '0;
  logic [SEL_W-1:0]          in_sel = '0;
  logic                      in_last = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_last;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready = '1;
  logic [CNT_W-1:0]          drop_cnt;

  always #5 clk = ~clk;

  demux_stream_n #(
    .DATA_W  (DATA_W),
    .NUM_OUT (NUM_OUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t        q[NUM_OUT][$];
  int           acc_cyc[NUM_OUT];
  bit           stall[NUM_OUT];
  int           drop_model = 0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  bit           random_rdy = 1'b0;
  logic [NUM_OUT-1:0] rdy_ctl = '1;
  int           release_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ready();
    if (random_rdy) begin
      for (int k = 0; k < NUM_OUT; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = rdy_ctl;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NUM_OUT; k++) begin
      q[k].delete();
      acc_cyc[k] = -10;
      stall[k]   = 1'b0;
    end
    drop_model = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_last", 32'(out_last), 32'h0);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    clear_model();
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    set_ready();
  endtask

  // Drives one beat until accepted; dest is the channel the packet belongs to.
  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] sel,
                            input logic last, input int dest, output int waited);
    bit    done;
    beat_t b;
    waited = 0;
    done   = 1'b0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    in_last  = last;
    set_ready();
    #2;
    while (!done) begin
      check("in_ready", 32'(in_ready),
            (dest >= NUM_OUT) ? 32'd1 : 32'(!out_valid[dest] || out_ready[dest]));
      if (in_ready) begin
        done = 1'b1;
      end else if (waited >= 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat 0x%0h to ch%0d never accepted", d, dest);
        return;
      end else begin
        waited++;
        @(negedge clk);
        #1;
        if (waited == release_at) rdy_ctl = '1;
        set_ready();
        #2;
      end
    end
    if (dest < NUM_OUT) begin
      b.last = last;
      b.data = d;
      q[dest].push_back(b);
      acc_cyc[dest] = cyc;
    end else begin
      drop_model = (drop_model >= CNT_MAX) ? CNT_MAX : drop_model + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      in_sel   = SEL_W'($urandom);
      in_data  = DATA_W'($urandom);
      set_ready();
    end
  endtask

  task automatic send_pkt(input int dest, input int len);
    int w;
    for (int i = 0; i < len; i++) begin
      drive_beat(DATA_W'($urandom), (i == 0) ? SEL_W'(dest) : SEL_W'($urandom),
                 (i == len - 1), dest, w);
    end
  endtask

  // Monitor: drop counter after every edge, channel outputs just before the next edge.
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (mon_en) check("drop_cnt", 32'(drop_cnt), 32'(drop_model));
      #4;
      if (mon_en) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (out_valid[k]) begin
            if (q[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: ch%0d data 0x%0h, expected none", k,
                       out_data[k*DATA_W +: DATA_W]);
            end else begin
              exp_b = q[k][0];
              check($sformatf("out_data_ch%0d", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(exp_b.data));
              check($sformatf("out_last_ch%0d", k), 32'(out_last[k]), 32'(exp_b.last));
              if (out_ready[k]) void'(q[k].pop_front());
            end
          end else begin
            if (acc_cyc[k] == cyc - 1) check($sformatf("latency_ch%0d", k), 32'(out_valid[k]), 32'd1);
            if (stall[k]) check($sformatf("stable_valid_ch%0d", k), 32'(out_valid[k]), 32'd1);
          end
          stall[k] = out_valid[k] && !out_ready[k];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clear_model();
    do_reset();

    // Single-beat packet
    drive_beat(8'hA5, 2'd2, 1'b1, 2, w);
    check("single_wait", 32'(w), 32'd0);
    idle(1);
    check("single_out_valid", 32'(out_valid), 32'b100);
    idle(1);

    // Three-beat packet, select changes after the first beat are ignored
    drive_beat(8'h11, 2'd1, 1'b0, 1, w);
    drive_beat(8'h22, 2'd2, 1'b0, 1, w);
    drive_beat(8'h33, 2'd0, 1'b1, 1, w);
    drive_beat(8'h44, 2'd0, 1'b1, 0, w);
    idle(3);

    // Back-pressure on ch0 while ch2 keeps flowing
    rdy_ctl = 3'b110;
    drive_beat(8'h55, 2'd0, 1'b1, 0, w);
    check("bp_first_wait", 32'(w), 32'd0);
    drive_beat(8'h66, 2'd2, 1'b0, 2, w);
    check("bp_other_ch_wait", 32'(w), 32'd0);
    drive_beat(8'h77, 2'd0, 1'b1, 2, w);
    check("bp_other_ch_wait2", 32'(w), 32'd0);
    release_at = 3;
    drive_beat(8'h88, 2'd0, 1'b1, 0, w);
    check("bp_stall_cycles", 32'(w), 32'd3);
    release_at = -1;
    rdy_ctl = '1;
    idle(3);

    // Sustained throughput on ch2
    for (int i = 0; i < 8; i++) begin
      drive_beat(DATA_W'(8'hC0 + i), (i == 0) ? 2'd2 : SEL_W'($urandom), (i == 7), 2, w);
      check("stream_wait", 32'(w), 32'd0);
    end
    idle(2);

    // Invalid select: whole packet dropped, then saturation
    send_pkt(3, 4);
    idle(1);
    check("drop_four", 32'(drop_cnt), 32'd4);
    check("drop_no_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) send_pkt(3, 3);
    idle(1);
    check("drop_saturated", 32'(drop_cnt), 32'(CNT_MAX));

    // Reset in the middle of a packet
    drive_beat(8'h91, 2'd1, 1'b0, 1, w);
    do_reset();
    drive_beat(8'h92, 2'd0, 1'b1, 0, w);
    idle(2);

    // Randomised traffic with random consumer back-pressure
    random_rdy = 1'b1;
    for (int p = 0; p < 80; p++) begin
      send_pkt($urandom_range(0, 3), $urandom_range(1, 4));
      idle($urandom_range(0, 2));
    end
    random_rdy = 1'b0;
    rdy_ctl = '1;
    idle(4);
    for (int k = 0; k < NUM_OUT; k++) check($sformatf("drained_ch%0d", k), 32'(q[k].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
